// File: rtl/pipe_stage_skid_reg.sv
// Valid/ready pipeline stage register with an optional skid entry. Control is forced to
// CTRL_RESET whenever no live instruction is held; the payload is only ever overwritten.
module pipe_stage_skid_reg #(
  parameter int unsigned          DATA_W     = 32,
  parameter int unsigned          CTRL_W     = 8,
  parameter logic [CTRL_W-1:0]    CTRL_RESET = '0,
  parameter int unsigned          SKID_EN    = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [CTRL_W-1:0] IN_CTRL,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [CTRL_W-1:0] OUT_CTRL,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [1:0]        OCCUPANCY
);

  typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;

  state_e              state_q;
  logic [CTRL_W-1:0]   main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0]   main_data_q, skid_data_q;
  logic                out_valid_q;
  logic                in_ready_q;
  logic [1:0]          occ_q;

  logic accept, drain;

  // With the skid entry, IN_READY is a flop so OUT_READY never reaches upstream combinationally.
  assign IN_READY  = (SKID_EN != 0) ? in_ready_q : (!out_valid_q || OUT_READY);
  assign accept    = IN_VALID && IN_READY;
  assign drain     = out_valid_q && OUT_READY;

  assign OUT_VALID = out_valid_q;
  assign OUT_CTRL  = main_ctrl_q;
  assign OUT_DATA  = main_data_q;
  assign OCCUPANCY = occ_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StEmpty;
      main_ctrl_q <= CTRL_RESET;
      main_data_q <= '0;
      skid_ctrl_q <= CTRL_RESET;
      skid_data_q <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      occ_q       <= 2'd0;
    end else if (FLUSH) begin
      // Payload is left alone; only validity and control are killed.
      state_q     <= StEmpty;
      main_ctrl_q <= CTRL_RESET;
      skid_ctrl_q <= CTRL_RESET;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      occ_q       <= 2'd0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            main_ctrl_q <= IN_CTRL;
            main_data_q <= IN_DATA;
            out_valid_q <= 1'b1;
            occ_q       <= 2'd1;
            state_q     <= StFull;
          end
        end
        StFull: begin
          if (drain && accept) begin
            main_ctrl_q <= IN_CTRL;
            main_data_q <= IN_DATA;
          end else if (drain) begin
            main_ctrl_q <= CTRL_RESET;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
            state_q     <= StEmpty;
          end else if (accept && (SKID_EN != 0)) begin
            skid_ctrl_q <= IN_CTRL;
            skid_data_q <= IN_DATA;
            in_ready_q  <= 1'b0;
            occ_q       <= 2'd2;
            state_q     <= StSkid;
          end
        end
        StSkid: begin
          if (drain) begin
            main_ctrl_q <= skid_ctrl_q;
            main_data_q <= skid_data_q;
            skid_ctrl_q <= CTRL_RESET;
            in_ready_q  <= 1'b1;
            occ_q       <= 2'd1;
            state_q     <= StFull;
          end
        end
        default: begin
          main_ctrl_q <= CTRL_RESET;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          occ_q       <= 2'd0;
          state_q     <= StEmpty;
        end
      endcase
    end
  end

endmodule
